// File: rtl/hist_mass_ctrl.sv
// hist_mass_ctrl: frame-level controller for an intensity histogram.
// Pixels are accepted in ACCUM and binned into NBIN saturating counters, and
// pixels at or below the latched threshold are counted in mass_count. The bins
// are then streamed out over a valid/ready port, and each bin is zeroed as it
// is read.
// Optional feature: define HIST_CUMULATIVE_EN to stream saturating running
// sums (pixel count with intensity <= bin_idx) instead of per-bin counts.
module hist_mass_ctrl #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PIX_W-1:0] thr,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_last,
    output logic             bin_valid,
    input  logic             bin_ready,
    output logic [PIX_W-1:0] bin_idx,
    output logic [CNT_W-1:0] bin_count,
    output logic             bin_last,
    output logic [CNT_W-1:0] mass_count,
    output logic             busy,
    output logic             done
);
    localparam int               NBIN       = 2**PIX_W;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [PIX_W-1:0] IDX_PENULT = PIX_W'(NBIN - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_READ
    } state_e;

    state_e           state_q;
    logic             pix_ready_q;
    logic             bin_valid_q;
    logic             bin_last_q;
    logic             busy_q;
    logic             done_q;
    logic [PIX_W-1:0] bin_idx_q;
    logic [PIX_W-1:0] thr_q;
    logic [CNT_W-1:0] mass_q;
    logic [CNT_W-1:0] mass_d;
    logic [CNT_W-1:0] bins_q [NBIN];
    logic [CNT_W-1:0] cur_pix;
    logic [CNT_W-1:0] bin_inc_d;
    logic [CNT_W-1:0] bin_sel;
    logic [CNT_W-1:0] bin_count_d;
    logic             pix_hs;
    logic             bin_hs;

    // pix_ready_q is high only in ACCUM and bin_valid_q only in READ, so the
    // two handshakes can never occur in the same cycle.
    assign pix_hs = pix_valid & pix_ready_q;
    assign bin_hs = bin_valid_q & bin_ready;

    // Saturating increments for the addressed bin and the mass counter.
    // NOTE: every signal gets a default at the top of the block so that no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        cur_pix   = bins_q[pix_data];
        bin_inc_d = (cur_pix == CNT_MAX) ? cur_pix : cur_pix + CNT_W'(1);
        bin_sel   = bins_q[bin_idx_q];
        mass_d    = mass_q;
        if (pix_hs && (pix_data <= thr_q) && (mass_q != CNT_MAX)) begin
            mass_d = mass_q + CNT_W'(1);
        end
    end

    // Bin storage: increment on a pixel handshake, clear on a readout handshake.
    // NOTE: this array is built from flops with an async reset on purpose.
    // Reset must leave every bin at zero, even mid-frame, and a RAM macro
    // could not clear all its entries at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBIN; i++) begin
                bins_q[i] <= '0;
            end
        end else if (pix_hs) begin
            bins_q[pix_data] <= bin_inc_d;
        end else if (bin_hs) begin
            bins_q[bin_idx_q] <= '0;
        end
    end

`ifdef HIST_CUMULATIVE_EN
    logic [CNT_W-1:0] cum_q;
    logic [CNT_W:0]   cum_sum;

    // Running sum up to and including the current bin, clamped at CNT_MAX.
    always_comb begin
        cum_sum     = {1'b0, cum_q} + {1'b0, bin_sel};
        bin_count_d = cum_sum[CNT_W] ? CNT_MAX : cum_sum[CNT_W-1:0];
    end

    // The running sum is held at zero outside READ, so each readout starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cum_q <= '0;
        end else if (state_q != S_READ) begin
            cum_q <= '0;
        end else if (bin_hs) begin
            cum_q <= bin_count_d;
        end
    end
`else
    // Per-bin count, read straight from the addressed bin.
    always_comb begin
        bin_count_d = bin_sel;
    end
`endif

    // Frame FSM. All handshake and status outputs are registered here.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pix_ready_q <= 1'b0;
            bin_valid_q <= 1'b0;
            bin_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bin_idx_q   <= '0;
            thr_q       <= '0;
            mass_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_ACCUM;
                        thr_q       <= thr;
                        mass_q      <= '0;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    mass_q <= mass_d;
                    if (pix_hs && pix_last) begin
                        state_q     <= S_READ;
                        pix_ready_q <= 1'b0;
                        bin_valid_q <= 1'b1;
                        bin_idx_q   <= '0;
                        bin_last_q  <= 1'b0;
                    end
                end
                S_READ: begin
                    if (bin_hs) begin
                        bin_idx_q  <= bin_idx_q + PIX_W'(1);
                        bin_last_q <= (bin_idx_q == IDX_PENULT);
                        if (bin_last_q) begin
                            state_q     <= S_IDLE;
                            bin_valid_q <= 1'b0;
                            bin_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pix_ready  = pix_ready_q;
    assign bin_valid  = bin_valid_q;
    assign bin_idx    = bin_idx_q;
    assign bin_count  = bin_count_d;
    assign bin_last   = bin_last_q;
    assign mass_count = mass_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_hist_mass_ctrl.sv
// tb_hist_mass_ctrl: directed and randomized frames for hist_mass_ctrl.
// Two instances share all inputs: dut_a uses the default 16-bit counters, and
// dut_b uses 4-bit counters so that saturation is reachable. The expected
// values come from a per-intensity pixel tally built from the frame's pixels.
module tb_hist_mass_ctrl;
    localparam int NBIN  = 256;
    localparam int CNT_A = 16;
    localparam int CNT_B = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             start     = 1'b0;
    logic [7:0]       thr       = '0;
    logic             pix_valid = 1'b0;
    logic [7:0]       pix_data  = '0;
    logic             pix_last  = 1'b0;
    logic             bin_ready = 1'b0;

    logic             pix_ready_a, bin_valid_a, bin_last_a, busy_a, done_a;
    logic [7:0]       bin_idx_a;
    logic [CNT_A-1:0] bin_count_a, mass_a;
    logic             pix_ready_b, bin_valid_b, bin_last_b, busy_b, done_b;
    logic [7:0]       bin_idx_b;
    logic [CNT_B-1:0] bin_count_b, mass_b;

    int               n_cmp  = 0;
    int               n_fail = 0;
    int unsigned      raw [NBIN];
    int unsigned      pix_q [$];

    hist_mass_ctrl #(.PIX_W(8), .CNT_W(CNT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .thr(thr),
        .pix_valid(pix_valid), .pix_ready(pix_ready_a), .pix_data(pix_data),
        .pix_last(pix_last), .bin_valid(bin_valid_a), .bin_ready(bin_ready),
        .bin_idx(bin_idx_a), .bin_count(bin_count_a), .bin_last(bin_last_a),
        .mass_count(mass_a), .busy(busy_a), .done(done_a)
    );

    hist_mass_ctrl #(.PIX_W(8), .CNT_W(CNT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .thr(thr),
        .pix_valid(pix_valid), .pix_ready(pix_ready_b), .pix_data(pix_data),
        .pix_last(pix_last), .bin_valid(bin_valid_b), .bin_ready(bin_ready),
        .bin_idx(bin_idx_b), .bin_count(bin_count_b), .bin_last(bin_last_b),
        .mass_count(mass_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int unsigned v, input int w);
        int unsigned m = (32'd1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    // Expected bin_count at idx for a w-bit counter, from the frame tally.
    function automatic logic [31:0] exp_count(input int idx, input int w);
        int unsigned s = 0;
`ifdef HIST_CUMULATIVE_EN
        for (int j = 0; j <= idx; j++) s += raw[j];
`else
        s = raw[idx];
`endif
        return sat(s, w);
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < NBIN; i++) raw[i] = 0;
    endfunction

    // mode: 0 = bin_ready held 1, 1 = bin_ready toggling, 2 = random gaps/stalls.
    // inj:  pulse start (with random thr) during ACCUM and READ.
    // abort_at: bin index at which rst_n is asserted mid-readout (-1 = never).
    task automatic run_frame(input int unsigned t, input int mode, input bit inj,
                             input int abort_at);
        int unsigned mass = 0;
        int          e;
        int          budget;
        // A pixel offered in IDLE must be refused and never counted.
        pix_valid = 1'b1;
        pix_data  = 8'd9;
        @(negedge clk);
        check("pix_ready_idle", pix_ready_a, 0);
        pix_valid = 1'b0;
        start     = 1'b1;
        thr       = 8'(t);
        @(negedge clk);
        start = 1'b0;
        check("busy_accum", busy_a, 1);
        check("pix_ready_accum", pix_ready_a, 1);
        for (int i = 0; i < pix_q.size(); i++) begin
            if (mode == 2) begin
                repeat ($urandom_range(2)) begin
                    pix_valid = 1'b0;
                    start     = inj;
                    thr       = 8'($urandom);
                    @(negedge clk);
                end
            end
            start     = inj && ($urandom_range(1) == 1);
            thr       = 8'($urandom);
            pix_valid = 1'b1;
            pix_data  = 8'(pix_q[i]);
            pix_last  = (i == pix_q.size() - 1);
            raw[pix_q[i]]++;
            if (pix_q[i] <= t) mass++;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        start     = 1'b0;
        check("mass_a", mass_a, sat(mass, CNT_A));
        check("mass_b", mass_b, sat(mass, CNT_B));
        check("pix_ready_read", pix_ready_a, 0);
        check("busy_read", busy_a, 1);

        e      = 0;
        budget = 0;
        while (e < NBIN) begin
            if (budget > 4 * NBIN) begin
                check("read_timeout_idx", e, NBIN);
                break;
            end
            budget++;
            if (e == abort_at) begin
                bin_ready = 1'b0;
                start     = 1'b0;
                rst_n     = 1'b0;
                #1;
                check("abort_bin_valid_a", bin_valid_a, 0);
                check("abort_bin_valid_b", bin_valid_b, 0);
                check("abort_busy_a", busy_a, 0);
                check("abort_mass_a", mass_a, 0);
                clear_model();
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("abort_idle_valid", bin_valid_a, 0);
                check("abort_idle_done", done_a, 0);
                return;
            end
            check("bin_valid", bin_valid_a, 1);
            check($sformatf("bin_idx_a[%0d]", e), bin_idx_a, e);
            check($sformatf("bin_idx_b[%0d]", e), bin_idx_b, e);
            check($sformatf("bin_count_a[%0d]", e), bin_count_a, exp_count(e, CNT_A));
            check($sformatf("bin_count_b[%0d]", e), bin_count_b, exp_count(e, CNT_B));
            check($sformatf("bin_last[%0d]", e), bin_last_a, (e == NBIN - 1) ? 1 : 0);
            case (mode)
                0:       bin_ready = 1'b1;
                1:       bin_ready = budget[0];
                default: bin_ready = 1'($urandom_range(1));
            endcase
            start = inj && ($urandom_range(3) == 0);
            thr   = 8'($urandom);
            @(negedge clk);
            if (bin_ready) e++;
        end
        bin_ready = 1'b0;
        start     = 1'b0;
        check("done_pulse", done_a, 1);
        check("done_pulse_b", done_b, 1);
        check("busy_after", busy_a, 0);
        check("bin_valid_after", bin_valid_a, 0);
        check("bin_last_after", bin_last_a, 0);
        check("mass_hold", mass_a, sat(mass, CNT_A));
        @(negedge clk);
        check("done_one_cycle", done_a, 0);
        check("idle_no_restart", busy_a, 0);
        clear_model();
    endtask

    task automatic random_pixels(input int n, input bit narrow);
        pix_q.delete();
        for (int i = 0; i < n; i++) begin
            pix_q.push_back(narrow ? $urandom_range(0, 15) : $urandom_range(0, 255));
        end
    endtask

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        check("rst_pix_ready", pix_ready_a, 0);
        check("rst_bin_valid", bin_valid_a, 0);
        check("rst_bin_last", bin_last_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_bin_idx", bin_idx_a, 0);
        check("rst_mass", mass_a, 0);
        check("rst_bin_count", bin_count_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy_a, 0);

        // Directed frame, readout with bin_ready toggling, then the same frame again.
        pix_q = '{5, 5, 200, 100};
        run_frame(100, 1, 1'b0, -1);
        pix_q = '{5, 5, 200, 100};
        run_frame(100, 1, 1'b0, -1);

        // Saturation: 20 pixels of value 7, thr 255.
        pix_q.delete();
        repeat (20) pix_q.push_back(7);
        run_frame(255, 0, 1'b0, -1);

        // Reset during readout at bin 40, then a fresh frame must show only new pixels.
        random_pixels(30, 1'b1);
        run_frame(8, 0, 1'b0, 40);
        random_pixels(12, 1'b0);
        run_frame(128, 0, 1'b0, -1);

        // start pulsed during ACCUM and READ must be ignored.
        random_pixels(25, 1'b1);
        run_frame(6, 2, 1'b1, -1);

        // Cumulative-semantics frame (also valid as per-bin frame).
        pix_q = '{0, 3, 3, 255};
        run_frame(0, 0, 1'b0, -1);

        // Single-pixel frames at the extreme intensities.
        pix_q = '{255};
        run_frame(254, 0, 1'b0, -1);
        pix_q = '{0};
        run_frame(0, 1, 1'b0, -1);

        // Randomized frames.
        for (int k = 0; k < 4; k++) begin
            random_pixels($urandom_range(1, 40), 1'(k % 2));
            run_frame($urandom_range(0, 255), 2, 1'(k % 2), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
